// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM with one-cycle valid/frame_err strobes.
// Optional 2-flop input synchronizer enabled by defining UART_RX_SYNC_EN.
module uart_rx #(
  parameter int CLK_FREQ  = 27_000_000,
  parameter int BOUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CYCLE = CLK_FREQ / BOUD_RATE;
  localparam int HALF  = CYCLE / 2;
  localparam int CW    = (CYCLE > 1) ? $clog2(CYCLE) : 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(CYCLE - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  // Both stages reset high so a reset never looks like a start edge.
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_pin};
    end
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx_pin;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        // Leave at stop mid-point so a back-to-back start edge is caught.
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = fe_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table of frames plus
// hand-written glitch, framing-error and mid-frame reset sequences.
module tb_uart_rx;

  localparam int CLK_FREQ = 160;
  localparam int BAUD     = 10;
  localparam int CYCLE    = CLK_FREQ / BAUD;
  localparam int HALF     = CYCLE / 2;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int LAT = 1 + HALF + 9 * CYCLE + SYNC_LAT;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_pin;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BOUD_RATE(BAUD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_pin   (rx_pin),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         fe_pending = 0;
  int         last_valid_cyc = -1;
  logic       prev_valid = 1'b0;
  logic       prev_fe = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] din;
    logic [7:0] dexp;
    int         gap;
  } vec_t;

  vec_t vecs[7];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      check("valid_fe_excl", {31'd0, frame_err}, 32'd0);
      check("valid_width", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got data %0h expected no pulse", data);
      end else begin
        check("rx_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
      end
      last_valid_cyc = cyc;
    end
    if (frame_err) begin
      check("fe_width", {31'd0, prev_fe}, 32'd0);
      checks++;
      if (fe_pending == 0) begin
        failures++;
        $display("FAIL unexpected_frame_err: got pulse expected none");
      end else begin
        fe_pending--;
      end
    end
    prev_valid = valid;
    prev_fe    = frame_err;
  end

  task automatic send_bit(logic v);
    rx_pin = v;
    repeat (CYCLE) @(negedge clk);
  endtask

  task automatic send_frame(logic [7:0] b, logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic idle(int n);
    rx_pin = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 4 * CYCLE) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    int t0;
    int lat;
    int t;
    vecs[0] = '{8'h41, 8'h41, 0};
    vecs[1] = '{8'hA5, 8'hA5, 5};
    vecs[2] = '{8'h00, 8'h00, 0};
    vecs[3] = '{8'hFF, 8'hFF, 3};
    vecs[4] = '{8'h80, 8'h80, 0};
    vecs[5] = '{8'h01, 8'h01, 7};
    vecs[6] = '{8'h3C, 8'h3C, 2};

    rst    = 1'b1;
    rx_pin = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_fe", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle(4);

    t0 = cyc;
    exp_q.push_back(8'h41);
    send_frame(8'h41, 1'b1);
    drain("t1_drain");
    lat = last_valid_cyc - t0;
    checks++;
    if (lat < LAT - 1 || lat > LAT + 1) begin
      failures++;
      $display("FAIL t1_latency: got %0d expected %0d", lat, LAT);
    end
    idle(3);
    check("t1_busy_idle", {31'd0, busy}, 32'd0);
    check("t1_data", {24'd0, data}, 32'h41);

    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(vecs[i].dexp);
      send_frame(vecs[i].din, 1'b1);
      if (vecs[i].gap > 0) idle(vecs[i].gap);
    end
    drain("table_drain");
    check("table_last", {24'd0, data}, {24'd0, vecs[6].dexp});

    idle(2);
    rx_pin = 1'b0;
    repeat (CYCLE / 4) @(negedge clk);
    check("glitch_busy_hi", {31'd0, busy}, 32'd1);
    rx_pin = 1'b1;
    repeat (HALF + 4) @(negedge clk);
    check("glitch_busy_lo", {31'd0, busy}, 32'd0);
    check("glitch_data", {24'd0, data}, {24'd0, vecs[6].dexp});

    fe_pending = 1;
    send_frame(8'h55, 1'b0);
    repeat (2 * CYCLE) @(negedge clk);
    check("fe_seen", fe_pending, 32'd0);
    check("fe_busy_hi", {31'd0, busy}, 32'd1);
    check("fe_data_kept", {24'd0, data}, {24'd0, vecs[6].dexp});
    rx_pin = 1'b1;
    repeat (4) @(negedge clk);
    check("fe_busy_lo", {31'd0, busy}, 32'd0);
    idle(CYCLE);
    exp_q.push_back(8'h33);
    send_frame(8'h33, 1'b1);
    drain("fe_next_drain");
    check("fe_next_data", {24'd0, data}, 32'h33);

    idle(CYCLE);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx_pin = 1'b1;
    repeat (HALF) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_data", {24'd0, data}, 32'd0);
    check("mrst_valid", {31'd0, valid}, 32'd0);
    check("mrst_fe", {31'd0, frame_err}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    idle(5 * CYCLE);
    check("mrst_quiet", {24'd0, data}, 32'd0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    drain("mrst_next_drain");
    check("mrst_next_data", {24'd0, data}, 32'h7E);

    t = 0;
    while (busy && t < 4 * CYCLE) begin
      @(negedge clk);
      t++;
    end
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_fe_pending", fe_pending, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
